// File: rtl/hazard_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// Contents: register-specifier width, default mult/div occupancy lengths,
// occupancy counter width, performance counter width, FSM state enum.
package hazard_pkg;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned MUL_CYCLES = 4;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned PERF_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_occupancy_fsm.sv
// Mult/div occupancy sequencer: tracks how long a multi-cycle op holds EX.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   md_start         - mult/div entering EX this cycle
//   md_div           - 1 = div, 0 = mult (qualified by md_start)
//   md_busy          - unit occupied (high exactly N cycles per operation)
//   md_done          - one-cycle pulse in the release cycle after the op
module md_occupancy_fsm #(
    parameter int unsigned MUL_CYCLES = hazard_pkg::MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = hazard_pkg::DIV_CYCLES,
    parameter int unsigned CNT_W      = hazard_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy,
    output logic md_done
);
    import hazard_pkg::*;

    md_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   load_idle;
    logic [CNT_W-1:0]   load_done;

    // From IDLE the start cycle itself is already busy, so BUSY runs N-1 cycles.
    // From DONE the start cycle is not busy, so BUSY must run the full N cycles.
    always_comb begin
        load_idle = md_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
        load_done = md_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    end

    // State register and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        state <= ST_BUSY;
                        cnt   <= load_idle;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (md_start) begin
                        state <= ST_BUSY;
                        cnt   <= load_done;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Busy includes the start cycle so the pipeline freezes the moment the op enters EX.
    assign md_busy = (state == ST_BUSY) | ((state == ST_IDLE) & md_start);
    assign md_done = (state == ST_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Produces hold/zero controls for pc, IF/ID, ID/EX and EX/MEM from load-use
// hazards, taken branches and mult/div occupancy.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   id_rs, id_rt               - source registers of the instruction in ID
//   ex_memread, ex_rt          - load in EX and its destination register
//   id_branch_taken            - branch/jump in ID resolved taken
//   ex_md_start, ex_md_div     - mult/div entering EX, 1 = div
//   pc_stall, ifid_stall       - hold PC / IF/ID
//   ifid_flush, idex_flush     - zero IF/ID / ID/EX
//   idex_hold, exmem_flush     - hold ID/EX / zero EX/MEM
//   md_busy, md_done           - mult/div occupancy and release pulse
// Optional feature (macro HAZARD_PERF_EN): perf_lu_cnt, perf_md_cnt,
// perf_br_cnt 32-bit wrapping event counters.
module hazard_ctrl #(
    parameter int unsigned REG_W      = hazard_pkg::REG_W,
    parameter int unsigned MUL_CYCLES = hazard_pkg::MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = hazard_pkg::DIV_CYCLES,
    parameter int unsigned CNT_W      = hazard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_branch_taken,
    input  logic             ex_md_start,
    input  logic             ex_md_div,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [hazard_pkg::PERF_W-1:0] perf_lu_cnt,
    output logic [hazard_pkg::PERF_W-1:0] perf_md_cnt,
    output logic [hazard_pkg::PERF_W-1:0] perf_br_cnt
`endif
);
    import hazard_pkg::*;

    logic lu;

    md_occupancy_fsm #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (ex_md_start),
        .md_div   (ex_md_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    // Load-use: r0 is never a real dependency.
    assign lu = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    // Priority: mult/div freeze, then load-use bubble, then branch flush.
    // On load-use the branch is not flushed; it re-resolves next cycle.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_hold   = 1'b0;
        exmem_flush = 1'b0;
        if (md_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters, wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt <= '0;
            perf_md_cnt <= '0;
            perf_br_cnt <= '0;
        end else begin
            if (lu & ~md_busy) perf_lu_cnt <= perf_lu_cnt + PERF_W'(1);
            if (md_busy)       perf_md_cnt <= perf_md_cnt + PERF_W'(1);
            if (ifid_flush)    perf_br_cnt <= perf_br_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a schedule-based reference model.
module tb_hazard_ctrl;

    localparam int N_MUL = 4;
    localparam int N_DIV = 32;
    localparam logic [7:0] V_BUSY = 8'b1100_1110;
    localparam logic [7:0] V_LU   = 8'b1101_0000;
    localparam logic [7:0] V_BR   = 8'b0010_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, id_branch_taken, ex_md_start, ex_md_div;
    logic       pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic       idex_hold, exmem_flush, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_md_cnt, perf_br_cnt;
`endif
    logic [7:0] outs;

    int checks = 0;
    int failures = 0;

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_flush,
                   idex_hold, exmem_flush, md_busy, md_done};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .id_branch_taken (id_branch_taken),
        .ex_md_start     (ex_md_start),
        .ex_md_div       (ex_md_div),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .idex_hold       (idex_hold),
        .exmem_flush     (exmem_flush),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt     (perf_lu_cnt),
        .perf_md_cnt     (perf_md_cnt),
        .perf_br_cnt     (perf_br_cnt)
`endif
    );

    task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic st,
                          input logic dv);
        ex_memread      = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        id_branch_taken = br;
        ex_md_start     = st;
        ex_md_div       = dv;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Advance until md_busy drops; returns busy cycles seen and whether the
    // freeze pattern held throughout. Leaves the bench in the first idle cycle.
    task automatic count_busy(input logic with_lu, output int cnt,
                              output logic stalls_ok, output logic to);
        cnt = 0;
        stalls_ok = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            if (with_lu) set_in(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
            else         set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            if (!md_busy) begin
                to = 1'b0;
                break;
            end
            cnt++;
            if (outs !== V_BUSY) stalls_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs: got %b expected %b", outs, 8'h00);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_release_outs: got %b expected %b", outs, 8'h00);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_lu_cnt !== 32'd0 || perf_md_cnt !== 32'd0 || perf_br_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_lu_cnt, perf_md_cnt, perf_br_cnt);
        end
`endif
    endtask

    task automatic test_load_use;
        logic [7:0] exp_v [4];
        logic [4:0] vec   [4][3];
        logic       mr    [4];
        exp_v[0] = V_LU;  vec[0][0] = 5'd8; vec[0][1] = 5'd8; vec[0][2] = 5'd3; mr[0] = 1'b1;
        exp_v[1] = V_LU;  vec[1][0] = 5'd8; vec[1][1] = 5'd3; vec[1][2] = 5'd8; mr[1] = 1'b1;
        exp_v[2] = 8'h00; vec[2][0] = 5'd0; vec[2][1] = 5'd0; vec[2][2] = 5'd0; mr[2] = 1'b1;
        exp_v[3] = 8'h00; vec[3][0] = 5'd8; vec[3][1] = 5'd8; vec[3][2] = 5'd8; mr[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_in(mr[i], vec[i][0], vec[i][1], vec[i][2], 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL load_use_%0d: got %b expected %b", i, outs, exp_v[i]);
            end
        end
    endtask

    task automatic test_branch;
        next_cycle();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== V_BR) begin
            failures++;
            $display("FAIL branch_only: got %b expected %b", outs, V_BR);
        end
        next_cycle();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== V_LU) begin
            failures++;
            $display("FAIL branch_with_lu: got %b expected %b", outs, V_LU);
        end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One mult or div from IDLE; optionally holds a load-use + branch during busy.
    task automatic test_md_op(input logic dv, input logic with_lu, input int exp_n,
                              input string name);
        int   n, extra;
        logic first_ok, stalls_ok, to;
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, dv);
        #1;
        n = md_busy ? 1 : 0;
        first_ok = (outs === V_BUSY);
        count_busy(with_lu, extra, stalls_ok, to);
        n += extra;
        checks++;
        if (to || n != exp_n) begin
            failures++;
            $display("FAIL %s_busy_len: got %0d (timeout %0b) expected %0d", name, n, to, exp_n);
        end
        checks++;
        if (!(first_ok && stalls_ok)) begin
            failures++;
            $display("FAIL %s_freeze: got first=%0b rest=%0b expected 1/1", name, first_ok, stalls_ok);
        end
        checks++;
        if (md_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_pulse: got %b expected 1", name, md_done);
        end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL %s_back_idle: got %b expected %b", name, outs, 8'h00);
        end
    endtask

    task automatic test_back_to_back;
        int   n1, n2;
        logic ok1, ok2, to1, to2;
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n1 = md_busy ? 1 : 0;
        count_busy(1'b0, n2, ok1, to1);
        n1 += n2;
        // DONE cycle: issue the second mult here
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (to1 || n1 != N_MUL || outs !== 8'b0000_0001) begin
            failures++;
            $display("FAIL b2b_first: got len=%0d outs=%b expected len=%0d outs=00000001",
                     n1, outs, N_MUL);
        end
        count_busy(1'b0, n2, ok2, to2);
        checks++;
        if (to2 || n2 != N_MUL || !ok2 || md_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got len=%0d freeze=%0b done=%b expected len=%0d freeze=1 done=1",
                     n2, ok2, md_done, N_MUL);
        end
    endtask

    task automatic test_async_reset;
        int   n, extra;
        logic ok, to;
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1;
        for (int i = 1; i < 10; i++) begin
            next_cycle();
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        end
        #1;
        checks++;
        if (outs !== V_BUSY) begin
            failures++;
            $display("FAIL arst_before: got %b expected %b", outs, V_BUSY);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL arst_immediate: got %b expected %b", outs, 8'h00);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL arst_release: got %b expected %b", outs, 8'h00);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_lu_cnt !== 32'd0 || perf_md_cnt !== 32'd0 || perf_br_cnt !== 32'd0) begin
            failures++;
            $display("FAIL arst_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_lu_cnt, perf_md_cnt, perf_br_cnt);
        end
`endif
        // A fresh mult after reset proves the counter restarted from scratch.
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n = md_busy ? 1 : 0;
        count_busy(1'b0, extra, ok, to);
        n += extra;
        checks++;
        if (to || n != N_MUL || md_done !== 1'b1) begin
            failures++;
            $display("FAIL arst_mult_after: got len=%0d done=%b expected len=%0d done=1",
                     n, md_done, N_MUL);
        end
    endtask

    // Random traffic. The model tracks each accepted op as an interval of busy
    // cycles followed by a single done cycle.
    task automatic test_random;
        int         busy_from, busy_until, done_at, opn;
        logic       mr, br, st, dv, e_busy, e_done, e_lu;
        logic [4:0] ert, rs, rt;
        logic [7:0] exp_v;
        logic [31:0] m_lu, m_md, m_br;
        busy_from = -1; busy_until = -2; done_at = -1;
        m_lu = '0; m_md = '0; m_br = '0;
        @(posedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int t = 0; t < 500; t++) begin
            next_cycle();
            mr  = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 7) == 0);
            dv  = ($urandom_range(0, 3) == 0);
            ert = 5'($urandom_range(0, 3));
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            set_in(mr, ert, rs, rt, br, st, dv);
            e_done = (t == done_at);
            if (st && !(t >= busy_from && t <= busy_until)) begin
                opn = dv ? N_DIV : N_MUL;
                if (e_done) begin
                    busy_from = t + 1; busy_until = t + opn; done_at = t + opn + 1;
                end else begin
                    busy_from = t; busy_until = t + opn - 1; done_at = t + opn;
                end
            end
            e_busy = (t >= busy_from && t <= busy_until);
            e_lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
            if (e_busy)    exp_v = V_BUSY;
            else if (e_lu) exp_v = V_LU;
            else if (br)   exp_v = V_BR;
            else           exp_v = 8'h00;
            exp_v[0] = e_done;
            #1;
            checks++;
            if (outs !== exp_v) begin
                failures++;
                $display("FAIL rand_cycle_%0d: got %b expected %b", t, outs, exp_v);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (perf_lu_cnt !== m_lu || perf_md_cnt !== m_md || perf_br_cnt !== m_br) begin
                failures++;
                $display("FAIL rand_perf_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", t,
                         perf_lu_cnt, perf_md_cnt, perf_br_cnt, m_lu, m_md, m_br);
            end
`endif
            if (e_lu && !e_busy)        m_lu++;
            if (e_busy)                 m_md++;
            if (br && !e_lu && !e_busy) m_br++;
        end
        // Let any in-flight op drain before returning.
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_md_op(1'b0, 1'b0, N_MUL, "mult");
        test_md_op(1'b1, 1'b1, N_DIV, "div");
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
